// File: rtl/trap_irq_ctrl.sv
// trap_irq_ctrl
//   Machine-mode trap controller. Selects between synchronous exceptions and
//   interrupts (software, timer, NUM_EXT synchronised external/local lines)
//   and drives the trap trigger and the trap target PC (direct or vectored).
//   It owns mie, mtvec, mepc, mcause, mip.MSIP, mtime and mtimecmp.
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   exceptSignal     exception requests, bit i = cause code i
//   extIrq           asynchronous level-sensitive external lines
//   MIE              mstatus.MIE global interrupt enable
//   instrValid       an instruction commits this cycle (interrupt window)
//   PC_trap          PC of the faulting/committing instruction
//   CSR_WriteEnable, CSR_addr, CSR_In   CSR write bus
//   csrRead          combinational read data for CSR_addr (0 when unmapped)
//   trapTrigger      take a trap this cycle (combinational)
//   trapTarget       next fetch PC on a trap, otherwise the mtvec base
//   mcause, mtvec, mepc   register values
//   irqPending       |(mip & mie), regardless of MIE
module trap_irq_ctrl #(
    parameter int N           = 64,
    parameter int NUM_EXT     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        exceptSignal,
    input  logic [NUM_EXT-1:0] extIrq,
    input  logic               MIE,
    input  logic               instrValid,
    input  logic [N-1:0]       PC_trap,
    input  logic               CSR_WriteEnable,
    input  logic [11:0]        CSR_addr,
    input  logic [N-1:0]       CSR_In,
    output logic [N-1:0]       csrRead,
    output logic               trapTrigger,
    output logic [N-1:0]       trapTarget,
    output logic [N-1:0]       mcause,
    output logic [N-1:0]       mtvec,
    output logic [N-1:0]       mepc,
    output logic               irqPending
);

    // MSIP, MTIP, MEIP and the local lines are the only implemented mie bits.
    localparam logic [N-1:0] MIE_MASK =
        N'((((64'd1 << NUM_EXT) - 64'd1) << 16) | 64'h888);

    logic [N-1:0] mie_q, mie_d;
    logic [N-1:0] mtvec_q, mtvec_d;
    logic [N-1:0] mepc_q, mepc_d;
    logic [N-1:0] mcause_q, mcause_d;
    logic         msip_q, msip_d;
    logic [N-1:0] mtime_q, mtime_d;
    logic [N-1:0] mtimecmp_q, mtimecmp_d;
    // Stage 0 samples extIrq; the last stage is what mip exposes.
    logic [SYNC_STAGES-1:0][NUM_EXT-1:0] sync_q, sync_d;

    logic         mtip;
    logic [N-1:0] mip_vec;
    logic [N-1:0] pend;
    logic         exc_any;
    logic [4:0]   exc_code;
    logic [4:0]   irq_code;
    logic [4:0]   sel_code;
    logic [N-1:0] cause_sel;
    logic [N-1:0] base;
    logic         unused_pc_bits;

    assign unused_pc_bits = ^PC_trap[1:0];

    assign mtip = (mtime_q >= mtimecmp_q);

    always_comb begin
        mip_vec    = '0;
        mip_vec[3] = msip_q;
        mip_vec[7] = mtip;
        for (int k = 0; k < NUM_EXT; k++) begin
            mip_vec[16+k] = sync_q[SYNC_STAGES-1][k];
        end
    end

    assign pend       = mip_vec & mie_q;
    assign irqPending = |pend;
    assign exc_any    = |exceptSignal;

    // Lowest-numbered exception wins; scan downward so the last hit is kept.
    always_comb begin
        exc_code = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (exceptSignal[i]) exc_code = 5'(i);
        end
    end

    // Interrupt priority: later assignments override earlier ones, giving
    // local lines (highest index first) > MEIP > MSIP > MTIP.
    always_comb begin
        irq_code = 5'd0;
        if (pend[7])  irq_code = 5'd7;
        if (pend[3])  irq_code = 5'd3;
        if (pend[11]) irq_code = 5'd11;
        for (int k = 0; k < NUM_EXT; k++) begin
            if (pend[16+k]) irq_code = 5'(16 + k);
        end
    end

    assign trapTrigger = exc_any | (MIE & instrValid & irqPending);
    assign sel_code    = exc_any ? exc_code : irq_code;

    always_comb begin
        cause_sel        = '0;
        cause_sel[4:0]   = sel_code;
        cause_sel[N-1]   = ~exc_any;
    end

    // Vectoring applies only to interrupts; exceptions always use the base.
    always_comb begin
        base       = {mtvec_q[N-1:2], 2'b00};
        trapTarget = base;
        if (trapTrigger && !exc_any && (mtvec_q[1:0] == 2'b01)) begin
            trapTarget = base + (N'(sel_code) << 2);
        end
    end

    always_comb begin
        csrRead = '0;
        case (CSR_addr)
            12'h304: csrRead = mie_q;
            12'h305: csrRead = mtvec_q;
            12'h341: csrRead = mepc_q;
            12'h342: csrRead = mcause_q;
            12'h344: csrRead = mip_vec;
            12'h7C0: csrRead = mtimecmp_q;
            12'h7C1: csrRead = mtime_q;
            default: csrRead = '0;
        endcase
    end

    always_comb begin
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = mtime_q + 1'b1;
        sync_d     = {sync_q[SYNC_STAGES-2:0], extIrq};
        if (CSR_WriteEnable) begin
            case (CSR_addr)
                12'h304: mie_d      = CSR_In & MIE_MASK;
                // Reserved modes (1x) collapse to direct.
                12'h305: mtvec_d    = {CSR_In[N-1:2], CSR_In[1] ? 2'b00 : {1'b0, CSR_In[0]}};
                12'h341: mepc_d     = {CSR_In[N-1:2], 2'b00};
                12'h342: mcause_d   = CSR_In;
                12'h344: msip_d     = CSR_In[3];
                12'h7C0: mtimecmp_d = CSR_In;
                12'h7C1: mtime_d    = CSR_In;
                default: ;
            endcase
        end
        // A trap overrides any same-cycle software write to mepc/mcause.
        if (trapTrigger) begin
            mepc_d   = {PC_trap[N-1:2], 2'b00};
            mcause_d = cause_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mie_q      <= '0;
            mtvec_q    <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            msip_q     <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            sync_q     <= '0;
        end else begin
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            msip_q     <= msip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            sync_q     <= sync_d;
        end
    end

    assign mcause = mcause_q;
    assign mtvec  = mtvec_q;
    assign mepc   = mepc_q;

endmodule

// File: tb/tb_trap_irq_ctrl.sv
// Bench for trap_irq_ctrl. Stimulus pushes expected values into two queues:
// per-cycle signal checks, and expected traps. A monitor at the falling edge
// drains the check queue and pops one trap record every time trapTrigger is
// high.
module tb_trap_irq_ctrl;
    localparam int N           = 64;
    localparam int NUM_EXT     = 4;
    localparam int SYNC_STAGES = 2;

    localparam int SIG_RD     = 0;
    localparam int SIG_TRIG   = 1;
    localparam int SIG_PEND   = 2;
    localparam int SIG_TARGET = 3;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] IRQ  = 64'h8000_0000_0000_0000;

    typedef struct {
        int          sig;
        logic [63:0] exp;
        string       name;
    } chk_t;

    typedef struct {
        logic [63:0] target;
        bit          chk_rd;
        logic [63:0] rd;
        string       name;
    } trap_t;

    logic               clk;
    logic               reset;
    logic [15:0]        exceptSignal;
    logic [NUM_EXT-1:0] extIrq;
    logic               MIE;
    logic               instrValid;
    logic [N-1:0]       PC_trap;
    logic               CSR_WriteEnable;
    logic [11:0]        CSR_addr;
    logic [N-1:0]       CSR_In;
    logic [N-1:0]       csrRead;
    logic               trapTrigger;
    logic [N-1:0]       trapTarget;
    logic [N-1:0]       mcause;
    logic [N-1:0]       mtvec;
    logic [N-1:0]       mepc;
    logic               irqPending;

    int    checks = 0;
    int    errors = 0;
    chk_t  chk_q[$];
    trap_t trap_q[$];

    trap_irq_ctrl #(.N(N), .NUM_EXT(NUM_EXT), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset), .exceptSignal(exceptSignal), .extIrq(extIrq),
        .MIE(MIE), .instrValid(instrValid), .PC_trap(PC_trap),
        .CSR_WriteEnable(CSR_WriteEnable), .CSR_addr(CSR_addr), .CSR_In(CSR_In),
        .csrRead(csrRead), .trapTrigger(trapTrigger), .trapTarget(trapTarget),
        .mcause(mcause), .mtvec(mtvec), .mepc(mepc), .irqPending(irqPending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor
    chk_t        mon_c;
    trap_t       mon_t;
    logic [63:0] mon_act;

    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            mon_c = chk_q.pop_front();
            case (mon_c.sig)
                SIG_RD:     mon_act = csrRead;
                SIG_TRIG:   mon_act = {63'd0, trapTrigger};
                SIG_PEND:   mon_act = {63'd0, irqPending};
                SIG_TARGET: mon_act = trapTarget;
                default:    mon_act = 'x;
            endcase
            checks++;
            if (mon_act !== mon_c.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", mon_c.name, mon_act, mon_c.exp);
            end
        end
        if (trapTrigger === 1'b1) begin
            checks++;
            if (trap_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_trap: trapTrigger=1 with target 0x%0h, expected no trap", trapTarget);
            end else begin
                mon_t = trap_q.pop_front();
                if (trapTarget !== mon_t.target) begin
                    errors++;
                    $display("FAIL %s_target: got 0x%0h, expected 0x%0h", mon_t.name, trapTarget, mon_t.target);
                end
                if (mon_t.chk_rd) begin
                    checks++;
                    if (csrRead !== mon_t.rd) begin
                        errors++;
                        $display("FAIL %s_when: csrRead 0x%0h, expected 0x%0h", mon_t.name, csrRead, mon_t.rd);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input int sig, input logic [63:0] exp, input string name);
        chk_t c;
        c.sig = sig; c.exp = exp; c.name = name;
        chk_q.push_back(c);
    endtask

    task automatic push_trap(input logic [63:0] target, input bit chk_rd,
                             input logic [63:0] rdv, input string name);
        trap_t t;
        t.target = target; t.chk_rd = chk_rd; t.rd = rdv; t.name = name;
        trap_q.push_back(t);
    endtask

    task automatic rd(input logic [11:0] addr, input logic [63:0] exp, input string name);
        CSR_addr = addr;
        expect_sig(SIG_RD, exp, name);
        cyc();
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [63:0] data);
        CSR_WriteEnable = 1'b1;
        CSR_addr        = addr;
        CSR_In          = data;
        cyc();
        CSR_WriteEnable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; exceptSignal = '0; extIrq = '0; MIE = 1'b0; instrValid = 1'b0;
        PC_trap = '0; CSR_WriteEnable = 1'b0; CSR_addr = '0; CSR_In = '0;
        repeat (3) cyc();
        expect_sig(SIG_TRIG, 0, "trig_in_reset");
        expect_sig(SIG_TARGET, 0, "target_in_reset");
        reset = 1'b0;

        // Reset values
        expect_sig(SIG_PEND, 0, "pend_reset");
        rd(12'h7C1, 64'd0, "mtime_after_reset");
        rd(12'h7C1, 64'd1, "mtime_counts");
        rd(12'h304, 64'd0, "mie_reset");
        rd(12'h305, 64'd0, "mtvec_reset");
        rd(12'h341, 64'd0, "mepc_reset");
        rd(12'h342, 64'd0, "mcause_reset");
        rd(12'h344, 64'd0, "mip_reset");
        rd(12'h7C0, ALL1, "mtimecmp_reset");
        rd(12'h300, 64'd0, "unmapped_read");

        // CSR field masking
        csr_wr(12'h305, 64'h303);
        rd(12'h305, 64'h300, "mtvec_mode_1x");
        csr_wr(12'h341, 64'h1237);
        rd(12'h341, 64'h1234, "mepc_low_bits");
        csr_wr(12'h304, ALL1);
        rd(12'h304, 64'hF0888, "mie_mask");
        csr_wr(12'h344, ALL1);
        expect_sig(SIG_PEND, 1, "pend_msip");
        rd(12'h344, 64'h8, "mip_msip_only");

        // Priority: local line 2 over MSIP/MTIP, then MSIP over MTIP
        csr_wr(12'h305, 64'h301);
        csr_wr(12'h7C0, 64'd0);
        extIrq = 4'b0101;
        repeat (3) cyc();
        MIE = 1'b1; instrValid = 1'b1; PC_trap = 64'h5000;
        push_trap(64'h348, 0, 0, "prio_local");
        cyc();
        MIE = 1'b0; instrValid = 1'b0;
        rd(12'h342, IRQ | 64'd18, "mcause_prio_local");
        extIrq = 4'b0000;
        repeat (3) cyc();
        MIE = 1'b1; instrValid = 1'b1;
        push_trap(64'h30C, 0, 0, "prio_msip");
        cyc();
        MIE = 1'b0; instrValid = 1'b0;
        rd(12'h342, IRQ | 64'd3, "mcause_prio_msip");
        csr_wr(12'h344, 64'd0);
        csr_wr(12'h7C0, ALL1);
        csr_wr(12'h304, 64'd0);
        rd(12'h344, 64'd0, "mip_cleared");

        // Exception beats a pending, enabled interrupt
        csr_wr(12'h305, 64'h100);
        csr_wr(12'h304, 64'h10000);
        extIrq = 4'b0001;
        repeat (3) cyc();
        exceptSignal = 16'h0804; PC_trap = 64'h1006; MIE = 1'b1; instrValid = 1'b1;
        push_trap(64'h100, 0, 0, "exc_over_irq");
        expect_sig(SIG_PEND, 1, "pend_during_exc");
        cyc();
        exceptSignal = '0; MIE = 1'b0; instrValid = 1'b0;
        rd(12'h342, 64'd2, "mcause_exc");
        rd(12'h341, 64'h1004, "mepc_exc");
        extIrq = 4'b0000;
        csr_wr(12'h304, 64'd0);

        // Timer interrupt fires in the cycle mtime reaches mtimecmp
        csr_wr(12'h304, 64'h80);
        csr_wr(12'h7C0, 64'd20);
        csr_wr(12'h7C1, 64'd17);
        MIE = 1'b1; instrValid = 1'b1; PC_trap = 64'h2000; CSR_addr = 12'h7C1;
        push_trap(64'h100, 1, 64'd20, "timer_trap");
        cyc();
        cyc();
        expect_sig(SIG_TRIG, 0, "no_trap_before_cmp");
        cyc();
        cyc();
        instrValid = 1'b0; MIE = 1'b0;
        rd(12'h342, IRQ | 64'd7, "mcause_timer");
        rd(12'h341, 64'h2000, "mepc_timer");
        instrValid = 1'b1;
        expect_sig(SIG_TRIG, 0, "timer_masked_by_mie");
        expect_sig(SIG_PEND, 1, "timer_pending_mie0");
        cyc();
        instrValid = 1'b0;
        csr_wr(12'h7C0, ALL1);
        csr_wr(12'h304, 64'd0);

        // Vectored external line 1 through the synchroniser
        csr_wr(12'h305, 64'h201);
        rd(12'h305, 64'h201, "mtvec_vectored");
        csr_wr(12'h304, 64'h20000);
        csr_wr(12'h7C1, 64'd100);
        extIrq = 4'b0010; MIE = 1'b1; instrValid = 1'b1; PC_trap = 64'h3000; CSR_addr = 12'h7C1;
        push_trap(64'h244, 1, 64'd102, "ext_vectored");
        expect_sig(SIG_PEND, 0, "ext_sync_cycle0");
        cyc();
        expect_sig(SIG_PEND, 0, "ext_sync_cycle1");
        cyc();
        cyc();
        instrValid = 1'b0; MIE = 1'b0;
        rd(12'h342, IRQ | 64'd17, "mcause_ext");
        rd(12'h341, 64'h3000, "mepc_ext");
        extIrq = 4'b0000;
        csr_wr(12'h304, 64'd0);

        // Trap wins over a same-cycle mcause write; read shows the old value
        CSR_WriteEnable = 1'b1; CSR_addr = 12'h342; CSR_In = 64'd5;
        exceptSignal = 16'h0008; PC_trap = 64'h4000;
        push_trap(64'h200, 0, 0, "exc_vs_mcause_wr");
        expect_sig(SIG_RD, IRQ | 64'd17, "mcause_no_bypass");
        cyc();
        CSR_WriteEnable = 1'b0; exceptSignal = '0;
        rd(12'h342, 64'd3, "mcause_trap_wins");
        rd(12'h341, 64'h4000, "mepc_exc3");
        // A write to an unrelated CSR proceeds alongside the trap
        CSR_WriteEnable = 1'b1; CSR_addr = 12'h304; CSR_In = 64'h80;
        exceptSignal = 16'h8000;
        push_trap(64'h200, 0, 0, "exc_vs_mie_wr");
        cyc();
        CSR_WriteEnable = 1'b0; exceptSignal = '0;
        rd(12'h304, 64'h80, "mie_write_proceeds");
        rd(12'h342, 64'd15, "mcause_exc15");
        csr_wr(12'h304, 64'd0);

        // Asynchronous reset mid-operation
        csr_wr(12'h7C1, 64'd1000);
        extIrq = 4'b0001;
        repeat (3) cyc();
        rd(12'h344, 64'h10000, "mip_ext_before_reset");
        rd(12'h7C1, 64'd1004, "mtime_before_reset");
        reset = 1'b1; CSR_addr = 12'h7C1;
        expect_sig(SIG_RD, 64'd0, "mtime_async_reset");
        cyc();
        CSR_addr = 12'h344;
        expect_sig(SIG_RD, 64'd0, "mip_async_reset");
        cyc();
        reset = 1'b0;
        rd(12'h344, 64'd0, "mip_resync_0");
        rd(12'h344, 64'd0, "mip_resync_1");
        rd(12'h344, 64'h10000, "mip_resync_2");
        extIrq = 4'b0000;
        cyc();

        checks++;
        if (trap_q.size() != 0) begin
            errors++;
            $display("FAIL missing_traps: %0d expected traps never seen, required 0", trap_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
